ws2812_rx_monitor: RTL and testbench
====================================

// Module: ws2812_rx_monitor
// PURPOSE
//  Downstream consumer of the ws2812 driver's serial output (mprj_io pin): decodes the NRZ pulse-width stream
//  back into 24-bit GRB pixels. Used in the caravel-level bench and as an on-chip loopback checker.
//  Pixels are buffered in a small FIFO and drained via valid/ready; frame ends and line errors are flagged.
// PARAMETERS
//  T_BIT_THRESH  24    high-time cycles; high < THRESH -> bit 0, >= THRESH -> bit 1 (40 MHz: T0H=16, T1H=32)
//  T_HIGH_MIN    4     high pulses shorter than this are glitches -> err_pulse, bit discarded
//  T_HIGH_MAX    60    high pulses longer than this -> err_pulse, bit discarded
//  T_RESET       2000  consecutive low cycles that terminate a frame (50 us at 40 MHz)
//  FIFO_DEPTH    4     pixel FIFO entries, power of 2, >= 2
//  IDX_W         8     width of pixel index within frame; saturates at all-ones
// PORTS
//  clk          in   1      system clock
//  RSTB         in   1      asynchronous active-low reset
//  din          in   1      ws2812 serial line, asynchronous to clk
//  pix_valid    out  1      FIFO head holds a pixel
//  pix_ready    in   1      consumer accepts head when pix_valid & pix_ready on rising clk
//  pix_data     out  24     {G[7:0],R[7:0],B[7:0]}, first-received bit at [23]
//  pix_index    out  IDX_W  position of head pixel within its frame (0 = first)
//  frame_done   out  1      one-cycle pulse when a T_RESET low gap ends a frame containing >= 1 bit
//  err_pulse    out  1      sticky: a high pulse was outside [T_HIGH_MIN, T_HIGH_MAX]
//  err_partial  out  1      sticky: frame ended with bit count not a multiple of 24
//  err_ovf      out  1      sticky: a pixel was dropped because FIFO was full
//  err_clr      in   1      synchronous clear of all three sticky flags (set wins if same cycle)
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, bit_cnt=0, pix_idx=0, state IDLE, counters 0, sync flops 0.
//  - din passes a 2-flop synchroniser; edges detected on synchronised value (2-cycle input latency).
//  - States: IDLE (line low, frame idle) -> HIGH on rising edge; HIGH -> LOW on falling edge;
//    LOW -> HIGH on rising edge; LOW -> IDLE when low counter reaches T_RESET. IDLE ignores low time.
//  - HIGH counts cycles (saturating, width sufficient for T_HIGH_MAX+1). On falling edge: if count in
//    range, shift bit into 24-bit shift reg, bit_cnt++; else set err_pulse, no shift.
//  - bit_cnt==24 after shift: push {shift reg} with current pix_idx into FIFO, bit_cnt<=0, pix_idx++
//    (saturating). Push visible as pix_valid 1 cycle after the falling edge is detected.
//  - LOW->IDLE: if bit_cnt!=0 set err_partial and discard partial bits; if any bit seen this frame,
//    pulse frame_done; pix_idx<=0. A rising edge exactly on the T_RESET cycle: reset gap wins, then
//    the edge starts the new frame's first HIGH.
//  - HIGH never times out to IDLE; line stuck high is reported only via err_pulse on eventual fall.
//  - FIFO: push and pop in same cycle allowed when full (net level unchanged, no overflow). Push when
//    full and no pop: pixel dropped, err_ovf set. pix_data/pix_index stable while pix_valid & !pix_ready.
//  - Pointers wrap modulo FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH.
//  - Async reset mid-frame: all state cleared; next rising edge treated as first bit of a new frame.
// TESTING
//  1 Frame of 2 pixels 0xFF0000,0x00A55A (T0H=16,T1H=32,low 18) + 2000 low, ready=1 -> two pixels
//    idx 0,1 exact data, frame_done one pulse, no errors.
//  2 Same frame with pix_ready=0, FIFO_DEPTH=4, 6 pixels -> 4 held, err_ovf=1, drain yields idx 0..3.
//  3 Full FIFO, pop on the cycle a new pixel pushes -> no overflow, order preserved.
//  4 Insert 2-cycle high glitch and 80-cycle high -> err_pulse=1, both bits dropped, err_clr clears it.
//  5 Send 30 bits then 2000 low -> one pixel out, err_partial=1, frame_done pulse, next frame idx 0.
//  6 Assert RSTB low mid-pixel (bit 12) then resume new frame -> outputs 0 during reset, clean decode after.

Source files
------------

// File: rtl/ws2812_rx_monitor.sv
// WS2812 NRZ line decoder: measures high-pulse widths, rebuilds 24-bit GRB pixels,
// buffers them in a small FIFO and flags frame ends and line errors.
module ws2812_rx_monitor #(
    parameter int T_BIT_THRESH = 24,
    parameter int T_HIGH_MIN   = 4,
    parameter int T_HIGH_MAX   = 60,
    parameter int T_RESET      = 2000,
    parameter int FIFO_DEPTH   = 4,
    parameter int IDX_W        = 8
) (
    input  logic             clk,
    input  logic             RSTB,
    input  logic             din,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [23:0]      pix_data,
    output logic [IDX_W-1:0] pix_index,
    output logic             frame_done,
    output logic             err_pulse,
    output logic             err_partial,
    output logic             err_ovf,
    input  logic             err_clr
);

    localparam int HIGH_W = $clog2(T_HIGH_MAX + 2);
    localparam int LOW_W  = $clog2(T_RESET + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t            state;
    logic              din_s1, din_s2, din_prev;
    logic [HIGH_W-1:0] high_cnt;
    logic [LOW_W-1:0]  low_cnt;
    logic [22:0]       shift_reg;
    logic [4:0]        bit_cnt;
    logic [IDX_W-1:0]  pix_idx;
    logic              frame_any;

    logic              rise, fall, pulse_ok, bit_val, gap_done, push_req;
    logic [23:0]       push_word;

    logic [23:0]       mem_data [FIFO_DEPTH];
    logic [IDX_W-1:0]  mem_idx  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              full, pop, push_ok;

    always_ff @(posedge clk or negedge RSTB) begin
        if (!RSTB) begin
            din_s1   <= 1'b0;
            din_s2   <= 1'b0;
            din_prev <= 1'b0;
        end else begin
            din_s1   <= din;
            din_s2   <= din_s1;
            din_prev <= din_s2;
        end
    end

    assign rise      = din_s2 & ~din_prev;
    assign fall      = ~din_s2 & din_prev;
    assign pulse_ok  = (high_cnt >= HIGH_W'(T_HIGH_MIN)) && (high_cnt <= HIGH_W'(T_HIGH_MAX));
    assign bit_val   = (high_cnt >= HIGH_W'(T_BIT_THRESH));
    // low_cnt already holds the earlier low cycles, so this cycle is the T_RESET-th one
    assign gap_done  = (low_cnt >= LOW_W'(T_RESET - 1));
    assign push_word = {shift_reg, bit_val};
    assign push_req  = (state == HIGH) && fall && pulse_ok && (bit_cnt == 5'd23);

    always_ff @(posedge clk or negedge RSTB) begin
        if (!RSTB) begin
            state       <= IDLE;
            high_cnt    <= '0;
            low_cnt     <= '0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            pix_idx     <= '0;
            frame_any   <= 1'b0;
            frame_done  <= 1'b0;
            err_pulse   <= 1'b0;
            err_partial <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (err_clr) begin
                err_pulse   <= 1'b0;
                err_partial <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (rise) begin
                        state    <= HIGH;
                        high_cnt <= HIGH_W'(1);
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state   <= LOW;
                        low_cnt <= LOW_W'(1);
                        if (pulse_ok) begin
                            shift_reg <= push_word[22:0];
                            frame_any <= 1'b1;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt <= '0;
                                if (pix_idx != {IDX_W{1'b1}}) pix_idx <= pix_idx + 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end else begin
                            err_pulse <= 1'b1;
                        end
                    end else if (high_cnt != HIGH_W'(T_HIGH_MAX + 1)) begin
                        high_cnt <= high_cnt + 1'b1;
                    end
                end
                LOW: begin
                    // The reset gap is honoured first; a coincident rise then opens the next frame
                    if (gap_done) begin
                        if (bit_cnt != 5'd0) err_partial <= 1'b1;
                        if (frame_any) frame_done <= 1'b1;
                        bit_cnt   <= '0;
                        pix_idx   <= '0;
                        frame_any <= 1'b0;
                        low_cnt   <= '0;
                        if (rise) begin
                            state    <= HIGH;
                            high_cnt <= HIGH_W'(1);
                        end else begin
                            state <= IDLE;
                        end
                    end else if (rise) begin
                        state    <= HIGH;
                        high_cnt <= HIGH_W'(1);
                    end else begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign full      = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign pix_valid = (fifo_cnt != '0);
    assign pop       = pix_valid & pix_ready;
    assign push_ok   = push_req & (~full | pop);
    assign pix_data  = mem_data[rd_ptr];
    assign pix_index = mem_idx[rd_ptr];

    // A push into a full FIFO succeeds only if the head leaves on the same edge
    always_ff @(posedge clk or negedge RSTB) begin
        if (!RSTB) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_idx[i]  <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            err_ovf  <= 1'b0;
        end else begin
            if (err_clr) err_ovf <= 1'b0;
            if (push_req && !push_ok) err_ovf <= 1'b1;
            if (push_ok) begin
                mem_data[wr_ptr] <= push_word;
                mem_idx[wr_ptr]  <= pix_idx;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok && !pop) fifo_cnt <= fifo_cnt + CNT_W'(1);
            else if (!push_ok && pop) fifo_cnt <= fifo_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ws2812_rx_monitor.sv
// Directed bench for ws2812_rx_monitor: drives NRZ bit streams and checks decoded pixels,
// FIFO behaviour, frame pulses and sticky error flags against hand-computed values.
module tb_ws2812_rx_monitor;

    logic        clk = 1'b0;
    logic        RSTB;
    logic        din;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_data;
    logic [7:0]  pix_index;
    logic        frame_done;
    logic        err_pulse;
    logic        err_partial;
    logic        err_ovf;
    logic        err_clr;

    int          passes = 0;
    int          checks = 0;
    int          fd_count = 0;
    int          fd_base;
    logic [23:0] got_data[$];
    int          got_idx[$];
    logic [23:0] px[6];

    ws2812_rx_monitor dut (
        .clk        (clk),
        .RSTB       (RSTB),
        .din        (din),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_index  (pix_index),
        .frame_done (frame_done),
        .err_pulse  (err_pulse),
        .err_partial(err_partial),
        .err_ovf    (err_ovf),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    // Pops happen on the rising edge after a negedge where valid & ready both hold
    initial begin
        forever begin
            @(negedge clk);
            if (RSTB === 1'b1 && pix_valid === 1'b1 && pix_ready === 1'b1) begin
                got_data.push_back(pix_data);
                got_idx.push_back(int'(pix_index));
            end
            if (frame_done === 1'b1) fd_count++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_pixel(input string tag, input int n, input logic [23:0] data, input int idx);
        logic [31:0] d_obs, i_obs;
        d_obs = (n < got_data.size()) ? 32'(got_data[n]) : 32'hxxxxxxxx;
        i_obs = (n < got_idx.size()) ? 32'(got_idx[n]) : 32'hxxxxxxxx;
        checkOutput({tag, "_data"}, d_obs, 32'(data));
        checkOutput({tag, "_idx"}, i_obs, 32'(idx));
    endtask

    // Each call starts and ends 1 time unit after a rising edge
    task automatic hold_line(input logic lvl, input int n);
        din = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        hold_line(1'b1, b ? 32 : 16);
        hold_line(1'b0, 18);
    endtask

    task automatic applyStimulus(input logic [31:0] value, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) send_bit(value[i]);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    task automatic drain();
        pix_ready = 1'b1;
        hold_line(1'b0, 10);
        pix_ready = 1'b0;
    endtask

    initial begin
        RSTB = 1'b0; din = 1'b0; pix_ready = 1'b0; err_clr = 1'b0;
        px[0] = 24'h123456; px[1] = 24'hABCDEF; px[2] = 24'h0F0F0F;
        px[3] = 24'hF0F0F0; px[4] = 24'h5A5A5B; px[5] = 24'hA5A5A5;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", 32'(pix_valid), 32'd0);
        checkOutput("reset_data", 32'(pix_data), 32'd0);
        checkOutput("reset_flags", {28'd0, frame_done, err_pulse, err_partial, err_ovf}, 32'd0);
        RSTB = 1'b1;
        hold_line(1'b0, 5);

        $display("[TB] two-pixel frame with consumer ready");
        got_data.delete(); got_idx.delete(); fd_base = fd_count;
        pix_ready = 1'b1;
        applyStimulus(32'hFF0000, 24);
        applyStimulus(32'h00A55A, 24);
        hold_line(1'b0, 2100);
        checkOutput("t1_count", 32'(got_data.size()), 32'd2);
        check_pixel("t1_p0", 0, 24'hFF0000, 0);
        check_pixel("t1_p1", 1, 24'h00A55A, 1);
        checkOutput("t1_frame_done", 32'(fd_count - fd_base), 32'd1);
        checkOutput("t1_errs", {29'd0, err_pulse, err_partial, err_ovf}, 32'd0);

        $display("[TB] six pixels into a stalled four-entry FIFO");
        got_data.delete(); got_idx.delete(); fd_base = fd_count;
        pix_ready = 1'b0;
        for (int k = 0; k < 6; k++) applyStimulus(32'(px[k]), 24);
        hold_line(1'b0, 2100);
        checkOutput("t2_ovf", 32'(err_ovf), 32'd1);
        checkOutput("t2_head_data", 32'(pix_data), 32'(px[0]));
        checkOutput("t2_head_idx", 32'(pix_index), 32'd0);
        checkOutput("t2_frame_done", 32'(fd_count - fd_base), 32'd1);
        drain();
        checkOutput("t2_count", 32'(got_data.size()), 32'd4);
        for (int k = 0; k < 4; k++) check_pixel($sformatf("t2_p%0d", k), k, px[k], k);
        checkOutput("t2_empty", 32'(pix_valid), 32'd0);
        pulse_clr();
        checkOutput("t2_ovf_clr", 32'(err_ovf), 32'd0);

        $display("[TB] pop coinciding with push into a full FIFO");
        got_data.delete(); got_idx.delete();
        for (int k = 0; k < 4; k++) applyStimulus(32'(px[k]), 24);
        applyStimulus(32'(px[4] >> 1), 23);
        hold_line(1'b1, px[4][0] ? 32 : 16);
        din = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        pix_ready = 1'b1;
        @(posedge clk);
        #1;
        pix_ready = 1'b0;
        checkOutput("t3_no_ovf", 32'(err_ovf), 32'd0);
        checkOutput("t3_head_idx", 32'(pix_index), 32'd1);
        hold_line(1'b0, 2100);
        drain();
        checkOutput("t3_count", 32'(got_data.size()), 32'd5);
        for (int k = 0; k < 5; k++) check_pixel($sformatf("t3_p%0d", k), k, px[k], k);
        checkOutput("t3_ovf_end", 32'(err_ovf), 32'd0);

        $display("[TB] glitch and over-long high pulses are discarded");
        got_data.delete(); got_idx.delete(); fd_base = fd_count;
        pix_ready = 1'b1;
        applyStimulus(32'h9ABCDE >> 14, 10);
        hold_line(1'b1, 2);
        hold_line(1'b0, 18);
        hold_line(1'b1, 80);
        hold_line(1'b0, 18);
        applyStimulus(32'h9ABCDE & 32'h3FFF, 14);
        hold_line(1'b0, 2100);
        checkOutput("t4_count", 32'(got_data.size()), 32'd1);
        check_pixel("t4_p0", 0, 24'h9ABCDE, 0);
        checkOutput("t4_err_pulse", 32'(err_pulse), 32'd1);
        checkOutput("t4_no_partial", 32'(err_partial), 32'd0);
        checkOutput("t4_frame_done", 32'(fd_count - fd_base), 32'd1);
        pulse_clr();
        checkOutput("t4_pulse_clr", 32'(err_pulse), 32'd0);

        $display("[TB] frame ending on a partial pixel");
        got_data.delete(); got_idx.delete(); fd_base = fd_count;
        applyStimulus(32'hC3C3C3, 24);
        applyStimulus(32'h2A, 6);
        hold_line(1'b0, 2100);
        checkOutput("t5_count", 32'(got_data.size()), 32'd1);
        check_pixel("t5_p0", 0, 24'hC3C3C3, 0);
        checkOutput("t5_partial", 32'(err_partial), 32'd1);
        checkOutput("t5_frame_done", 32'(fd_count - fd_base), 32'd1);
        applyStimulus(32'h010203, 24);
        hold_line(1'b0, 2100);
        check_pixel("t5_next", 1, 24'h010203, 0);

        $display("[TB] asynchronous reset in the middle of a pixel");
        got_data.delete(); got_idx.delete();
        pix_ready = 1'b0;
        applyStimulus(32'h13579B, 24);
        applyStimulus(32'h7E8, 12);
        hold_line(1'b1, 10);
        checkOutput("t6_pre_valid", 32'(pix_valid), 32'd1);
        #2;
        RSTB = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 32'(pix_valid), 32'd0);
        checkOutput("t6_rst_data", {pix_data, pix_index}, 32'd0);
        checkOutput("t6_rst_flags", {28'd0, frame_done, err_pulse, err_partial, err_ovf}, 32'd0);
        @(posedge clk);
        #1;
        hold_line(1'b0, 5);
        RSTB = 1'b1;
        hold_line(1'b0, 3);
        fd_base = fd_count;
        pix_ready = 1'b1;
        applyStimulus(32'h7E817E, 24);
        hold_line(1'b0, 2100);
        checkOutput("t6_count", 32'(got_data.size()), 32'd1);
        check_pixel("t6_p0", 0, 24'h7E817E, 0);
        checkOutput("t6_errs", {29'd0, err_pulse, err_partial, err_ovf}, 32'd0);
        checkOutput("t6_frame_done", 32'(fd_count - fd_base), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
